// File: rtl/mc_pkg.sv
// Shared types and opcode constants for the multicycle phase sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StMem,
    StWriteback,
    StHalt,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    CauseNone        = 2'b00,
    CauseIllegal     = 2'b01,
    CauseImemTimeout = 2'b10,
    CauseDmemTimeout = 2'b11
  } trap_cause_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC,
      OP_SYSTEM: is_legal_op = 1'b1;
      default:   is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state timer: counts stalled request cycles, flags the last allowed one.
module mc_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
        cnt_d = '0;
      end else if (en_i) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Fires on the stalled cycle that would bring the count to the limit.
    assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle phase sequencer gating datapath write enables with memory req/ready handshakes.
// Performance counters are built only when MC_PERF_CNT_EN is defined.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             run_i,
  input  logic [6:0]       opcode_i,
  input  logic             dec_reg_wr_i,
  input  logic             dec_mem_wr_i,
  input  logic             imem_ready_i,
  input  logic             dmem_ready_i,
  output logic             imem_req_o,
  output logic             ir_wr_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             reg_wr_o,
  output logic             pc_wr_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instret_cnt_o
);

  state_e      state_q, state_d;
  trap_cause_e cause_q, cause_d;
  logic        imem_req_q, dmem_req_q, pc_wr_q, busy_q, halted_q, trap_q;
  logic        state_chg, tmr_en, tmr_expired;

  assign state_chg = (state_d != state_q);
  assign tmr_en    = (imem_req_q & ~imem_ready_i) | (dmem_req_q & ~dmem_ready_i);

  mc_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk_i    (clock_i),
    .rst_ni   (reset_ni),
    .clear_i  (state_chg),
    .en_i     (tmr_en),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      StIdle: if (run_i) state_d = StFetch;
      StFetch: begin
        if (imem_ready_i) begin
          state_d = StDecode;
        end else if (tmr_expired) begin
          state_d = StTrap;
          cause_d = CauseImemTimeout;
        end
      end
      StDecode: begin
        if (!is_legal_op(opcode_i)) begin
          state_d = StTrap;
          cause_d = CauseIllegal;
        end else if (opcode_i == OP_SYSTEM) begin
          state_d = StHalt;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        state_d = (opcode_i == OP_LOAD || opcode_i == OP_STORE) ? StMem : StWriteback;
      end
      StMem: begin
        if (dmem_ready_i) begin
          state_d = StWriteback;
        end else if (tmr_expired) begin
          state_d = StTrap;
          cause_d = CauseDmemTimeout;
        end
      end
      StWriteback: state_d = run_i ? StFetch : StIdle;
      StHalt, StTrap: state_d = state_q;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      cause_q    <= CauseNone;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      pc_wr_q    <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      imem_req_q <= (state_d == StFetch);
      dmem_req_q <= (state_d == StMem);
      pc_wr_q    <= (state_d == StWriteback);
      busy_q     <= state_d inside {StFetch, StDecode, StExecute, StMem, StWriteback};
      halted_q   <= (state_d == StHalt);
      trap_q     <= (state_d == StTrap);
    end
  end

  // IR must latch on the very edge that ends the fetch, so ir_wr follows ready directly.
  assign imem_req_o   = imem_req_q;
  assign ir_wr_o      = imem_req_q & imem_ready_i;
  assign dmem_req_o   = dmem_req_q;
  assign dmem_we_o    = dmem_req_q & dec_mem_wr_i;
  assign reg_wr_o     = pc_wr_q & dec_reg_wr_i;
  assign pc_wr_o      = pc_wr_q;
  assign busy_o       = busy_q;
  assign halted_o     = halted_q;
  assign trap_o       = trap_q;
  assign trap_cause_o = cause_q;

`ifdef MC_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  // ECALL/EBREAK retire at decode since they never reach writeback.
  assign retire = (state_q == StWriteback) || (state_q == StDecode && state_d == StHalt);

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (busy_q) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (retire) instret_cnt_q <= instret_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign instret_cnt_o = instret_cnt_q;
`else
  assign cycle_cnt_o   = '0;
  assign instret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: per-instruction phase schedule derived from the timing rules.
module tb_multicycle_controller;

  localparam int unsigned T = 4;
  localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  localparam logic [6:0] SYS = 7'b1110011;

  logic        clock = 1'b0, reset_n = 1'b0, run = 1'b0;
  logic [6:0]  opcode = '0;
  logic        dec_reg_wr = 1'b0, dec_mem_wr = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        imem_req, ir_wr, dmem_req, dmem_we, reg_wr, pc_wr, busy, halted, trap;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [10:0] obs;

  int          n_tests = 0, n_fail = 0;
  logic [31:0] m_cyc = '0, m_ret = '0;
  logic [6:0]  legal_ops [9] = '{R_OP, I_OP, LD, ST, BR, JAL, JALR, LUI, AUIPC};

  multicycle_controller #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (32)
  ) dut (
    .clock_i      (clock),
    .reset_ni     (reset_n),
    .run_i        (run),
    .opcode_i     (opcode),
    .dec_reg_wr_i (dec_reg_wr),
    .dec_mem_wr_i (dec_mem_wr),
    .imem_ready_i (imem_ready),
    .dmem_ready_i (dmem_ready),
    .imem_req_o   (imem_req),
    .ir_wr_o      (ir_wr),
    .dmem_req_o   (dmem_req),
    .dmem_we_o    (dmem_we),
    .reg_wr_o     (reg_wr),
    .pc_wr_o      (pc_wr),
    .busy_o       (busy),
    .halted_o     (halted),
    .trap_o       (trap),
    .trap_cause_o (trap_cause),
    .cycle_cnt_o  (cycle_cnt),
    .instret_cnt_o(instret_cnt)
  );

  always #5 clock = ~clock;

  assign obs = {imem_req, ir_wr, dmem_req, dmem_we, reg_wr, pc_wr, busy, halted, trap, trap_cause};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ov(input bit ireq, irw, dreq, dwe, rw, pw, bsy, hlt, trp,
                                     input logic [1:0] c);
    return {ireq, irw, dreq, dwe, rw, pw, bsy, hlt, trp, c};
  endfunction

  // One clock cycle: check outputs and counters mid-cycle, then advance the model.
  task automatic cyc(input string tag, input logic [10:0] exp, input bit retire);
    @(negedge clock);
    check_eq(tag, 64'(obs), 64'(exp));
`ifdef MC_PERF_CNT_EN
    check_eq({tag, "/cycle_cnt"}, 64'(cycle_cnt), 64'(m_cyc));
    check_eq({tag, "/instret_cnt"}, 64'(instret_cnt), 64'(m_ret));
`else
    check_eq({tag, "/cnt_tied"}, {cycle_cnt, instret_cnt}, 64'd0);
`endif
    if (exp[4]) m_cyc++;
    if (retire) m_ret++;
    @(posedge clock);
    #1;
  endtask

  task automatic sticky_tail(input string tag, input bit hlt, input logic [1:0] c);
    for (int i = 0; i < 3; i++) begin
      run = 1'($urandom); imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
      opcode = 7'($urandom);
      cyc(tag, ov(0, 0, 0, 0, 0, 0, 0, hlt, !hlt, hlt ? 2'b00 : c), 0);
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1 check_eq("reset_outputs", 64'(obs), 64'd0);
    check_eq("reset_counters", {cycle_cnt, instret_cnt}, 64'd0);
    m_cyc = '0;
    m_ret = '0;
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic start();
    run = 1'b1;
    cyc("idle_start", 11'd0, 0);
  endtask

  // status: 0 continues, 1 halted, 2 trapped, 3 reset applied mid-MEM.
  task automatic do_instr(input logic [6:0] op, input bit rw, input bit mw, input int wi,
                          input int wd, input bit run_after, input int rst_mem,
                          output int status);
    bit legal, ismem;
    legal  = (op inside {R_OP, I_OP, LD, ST, BR, JAL, JALR, LUI, AUIPC, SYS});
    ismem  = (op == LD) || (op == ST);
    status = 0;
    opcode = op; dec_reg_wr = rw; dec_mem_wr = mw;
    for (int k = 0; k <= wi; k++) begin
      imem_ready = (k == wi); dmem_ready = 1'($urandom);
      cyc("fetch", ov(1, k == wi, 0, 0, 0, 0, 1, 0, 0, 2'b00), 0);
      if (k == wi) break;
      if (k == int'(T) - 1) begin
        imem_ready = 1'b0;
        sticky_tail("imem_timeout", 0, 2'b10);
        status = 2;
        return;
      end
    end
    imem_ready = 1'($urandom);
    if (!legal) begin
      cyc("decode_illegal", ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00), 0);
      sticky_tail("illegal_trap", 0, 2'b01);
      status = 2;
      return;
    end
    if (op == SYS) begin
      cyc("decode_sys", ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00), 1);
      sticky_tail("halt", 1, 2'b00);
      status = 1;
      return;
    end
    cyc("decode", ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00), 0);
    run = run_after;
    cyc("execute", ov(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00), 0);
    if (ismem) begin
      for (int k = 0; k <= wd; k++) begin
        dmem_ready = (k == wd); imem_ready = 1'($urandom);
        cyc("mem", ov(0, 0, 1, mw, 0, 0, 1, 0, 0, 2'b00), 0);
        if (k == wd) break;
        if (k == rst_mem) begin
          check_eq("mem_before_reset", 64'(dmem_req), 64'd1);
          do_reset();
          status = 3;
          return;
        end
        if (k == int'(T) - 1) begin
          dmem_ready = 1'b0;
          sticky_tail("dmem_timeout", 0, 2'b11);
          status = 2;
          return;
        end
      end
    end
    dmem_ready = 1'($urandom);
    cyc("writeback", ov(0, 0, 0, 0, rw, 1, 1, 0, 0, 2'b00), 1);
    if (!run_after) begin
      cyc("idle_stopped", 11'd0, 0);
      run = 1'b1;
      cyc("idle_restart", 11'd0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic [6:0] op;
    do_reset();
    start();
    do_instr(R_OP, 1, 0, 0, 0, 1, -1, st);                  // zero-wait ADD
    do_instr(LD, 1, 0, 0, 3, 1, -1, st);                    // load with 3 waits
    do_instr(ST, 0, 1, 1, 1, 1, -1, st);                    // store
    do_instr(I_OP, 1, 0, T - 1, 0, 1, -1, st);              // ready on the limit cycle
    do_instr(ST, 0, 1, 0, T - 1, 1, -1, st);
    do_instr(LD, 1, 0, 2, 1, 0, -1, st);                    // run dropped mid-instruction
    do_instr(JAL, 1, 0, 0, 0, 0, -1, st);
    for (int i = 0; i < 40; i++) begin
      op = legal_ops[$urandom_range(0, 8)];
      do_instr(op, 1'($urandom), op == ST, $urandom_range(0, T - 1), $urandom_range(0, T - 1),
               ($urandom_range(0, 3) != 0), -1, st);
    end
    do_instr(R_OP, 1, 0, T, 0, 1, -1, st);                  // imem timeout
    check_eq("imem_timeout_status", 64'(st), 64'd2);
    do_reset(); start();
    do_instr(LD, 1, 0, 0, T + 2, 1, -1, st);                // dmem timeout
    do_reset(); start();
    do_instr(7'b1111111, 1, 0, 0, 0, 1, -1, st);            // illegal opcode
    do_reset(); start();
    do_instr(SYS, 0, 0, 1, 0, 1, -1, st);                   // halt
    check_eq("halt_status", 64'(st), 64'd1);
    do_reset(); start();
    do_instr(LD, 1, 0, 0, T + 2, 1, 1, st);                 // async reset mid-MEM
    check_eq("abort_status", 64'(st), 64'd3);
    for (int r = 0; r < 6; r++) begin
      start();
      st = 0;
      for (int i = 0; i < 20 && st == 0; i++) begin
        case ($urandom_range(0, 9))
          0:       op = 7'b1111111 ^ 7'($urandom_range(0, 3) << 5);
          1:       op = SYS;
          default: op = legal_ops[$urandom_range(0, 8)];
        endcase
        do_instr(op, 1'($urandom), 1'($urandom), $urandom_range(0, T), $urandom_range(0, T),
                 ($urandom_range(0, 3) != 0), -1, st);
      end
      do_reset();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Phase sequencer that turns the single-cycle datapath into a multicycle core with wait-state-capable instruction and data memories.
- Holds the FSM that gates the existing write enables (PC, instruction register, register file, data memory) per phase.
- Handshakes each memory with req/ready.
- Detects illegal opcodes, memory timeouts and ECALL/EBREAK halts.
- Sits beside the decoder: decoder still produces datapath selects; this block only sequences enables.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles a memory req may wait for ready before trap; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- run  in  1  start/continue execution.
- opcode  in  7  inst[6:0] from the instruction register.
- dec_reg_wr  in  1  decoder register-write request.
- dec_mem_wr  in  1  decoder store flag.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_wr  out  1  latch instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write strobe.
- reg_wr  out  1  register file write enable.
- pc_wr  out  1  PC update enable.
- busy  out  1  FSM not in IDLE/HALT/TRAP.
- halted  out  1  ECALL/EBREAK reached.
- trap  out  1  fault stop.
- trap_cause  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout.
- cycle_cnt  out  CNT_W  cycles while busy.
- instret_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; counters 0; wait timer 0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, TRAP.
- IDLE: go to FETCH when run=1.
- FETCH:
  - imem_req=1 every cycle in this state.
  - When imem_ready=1: ir_wr=1 for that cycle, then go to DECODE.
  - Timer reaching TIMEOUT_CYCLES with no ready: go to TRAP, cause 10.
- DECODE: one cycle.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011}: go to TRAP, cause 01.
  - Opcode 1110011: go to HALT; it is retired, so instret_cnt increments.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - Opcode 0000011 or 0100011: go to MEM.
  - Otherwise go to WRITEBACK.
- MEM:
  - dmem_req=1 held each cycle; dmem_we = dec_mem_wr.
  - dmem_ready=1: go to WRITEBACK.
  - Timeout: go to TRAP, cause 11; dmem_we drops to 0 the same edge.
- WRITEBACK: one cycle.
  - reg_wr = dec_reg_wr; pc_wr=1; instret_cnt += 1.
  - Next state is FETCH if run=1, else IDLE.
- CPI with zero-wait memories: 4 for non-memory instructions, 5 for loads/stores.
- run=0 mid-instruction: the instruction completes; the controller stops at the WRITEBACK boundary and never abandons a memory access.
- HALT and TRAP are sticky; only reset exits them. In these states all enables are 0; halted or trap=1 respectively.
- Wait timer:
  - Clears on every state change.
  - Counts while req=1 and ready=0.
  - ready arriving on the same cycle the timer hits the limit counts as success; ready has priority.
- reg_wr, pc_wr, ir_wr: single-cycle pulses, never asserted in the same cycle as dmem_req.
- Counters wrap modulo 2^CNT_W.

Optional Feature:
- Macro: MC_PERF_CNT_EN.
- Defined: cycle_cnt and instret_cnt behave as above.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Decomposition:
- Package mc_pkg:
  - state_e enum (3 bits).
  - trap_cause_e.
  - Opcode localparams OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM.
- Sub-module mc_wait_timer: clear/enable inputs, expired output, width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Reset and zero-wait ADD:
  - Stimulus: reset low then high; run=1; opcode=0110011; dec_reg_wr=1; ready tied 1.
  - Required: states FETCH, DECODE, EXECUTE, WRITEBACK; reg_wr and pc_wr pulse on cycle 4; instret_cnt=1.
- Load with waits:
  - Stimulus: opcode=0000011; dmem_ready asserted after 3 wait cycles.
  - Required: dmem_req high for 4 cycles with dmem_we=0; then WRITEBACK; total 8 cycles.
- Store:
  - Stimulus: opcode=0100011; dec_mem_wr=1; dec_reg_wr=0.
  - Required: dmem_we=1 while in MEM; reg_wr stays 0; pc_wr pulses once.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4; imem_ready held 0.
  - Required: trap=1, trap_cause=10 after 4 FETCH cycles; stays until reset.
- Illegal opcode and halt:
  - Stimulus: opcode=1111111.
  - Required: TRAP with cause 01.
  - Stimulus: after reset, opcode=1110011.
  - Required: halted=1; instret_cnt=1.
- Stop and async reset:
  - Stimulus: run dropped during EXECUTE.
  - Required: instruction finishes; IDLE follows WRITEBACK.
  - Stimulus: reset pulled low mid-MEM.
  - Required: dmem_req=0 immediately, without waiting for a clock edge.
